// File: rtl/vta_mem_mux.sv
// Multiplexes NUM_CH client channels onto one memory port, one burst at a time,
// with round-robin request arbitration and a small read-return buffer.
module vta_mem_mux #(
  parameter int NUM_CH        = 2,
  parameter int LEN_BITS      = 8,
  parameter int ADDR_BITS     = 64,
  parameter int DATA_BITS     = 64,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_req_valid,
  output logic [NUM_CH-1:0]             ch_req_ready,
  input  logic [NUM_CH-1:0]             ch_req_opcode,
  input  logic [NUM_CH*LEN_BITS-1:0]    ch_req_len,
  input  logic [NUM_CH*ADDR_BITS-1:0]   ch_req_addr,
  input  logic [NUM_CH-1:0]             ch_wr_valid,
  output logic [NUM_CH-1:0]             ch_wr_ready,
  input  logic [NUM_CH*DATA_BITS-1:0]   ch_wr_bits,
  output logic [NUM_CH-1:0]             ch_rd_valid,
  input  logic [NUM_CH-1:0]             ch_rd_ready,
  output logic [DATA_BITS-1:0]          ch_rd_bits,
  output logic                          mem_req_valid,
  output logic                          mem_req_opcode,
  output logic [LEN_BITS-1:0]           mem_req_len,
  output logic [ADDR_BITS-1:0]          mem_req_addr,
  output logic                          mem_wr_valid,
  output logic [DATA_BITS-1:0]          mem_wr_bits,
  input  logic                          mem_rd_valid,
  input  logic [DATA_BITS-1:0]          mem_rd_bits,
  output logic                          mem_rd_ready,
  output logic [1:0]                    fsm_state
);

  // Handshakes: a beat or request transfers on a rising edge where valid and
  // ready are both high; ready never depends on a channel other than the grant.
  localparam int PTR_W   = $clog2(NUM_CH);
  localparam int FIFO_AW = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W   = LEN_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, grant_q, grant_d, ptr_next;
  logic                   grant_found;
  logic [PTR_W:0]         cand;
  logic                   op_q;
  logic [LEN_BITS-1:0]    len_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [CNT_W-1:0]       beat_cnt_q, rx_cnt_q, beats_total;
  logic                   last_beat, wr_fire, rd_accept, push, pop;
  logic [DATA_BITS-1:0]   fifo_mem [RD_FIFO_DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]       fifo_cnt_q;
  logic                   fifo_full, fifo_empty;

  logic [LEN_BITS-1:0]    len_arr  [NUM_CH];
  logic [ADDR_BITS-1:0]   addr_arr [NUM_CH];
  logic [DATA_BITS-1:0]   wdat_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign len_arr[i]  = ch_req_len[i*LEN_BITS +: LEN_BITS];
    assign addr_arr[i] = ch_req_addr[i*ADDR_BITS +: ADDR_BITS];
    assign wdat_arr[i] = ch_wr_bits[i*DATA_BITS +: DATA_BITS];
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_d     = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_CH)) cand = cand - (PTR_W+1)'(NUM_CH);
      if (!grant_found && ch_req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_d     = cand[PTR_W-1:0];
      end
    end
    ptr_next = (grant_d == PTR_W'(NUM_CH - 1)) ? '0 : grant_d + PTR_W'(1);
  end

  assign beats_total = {1'b0, len_q} + CNT_W'(1);
  assign last_beat   = (beat_cnt_q == {1'b0, len_q});
  assign fifo_full   = (fifo_cnt_q == (FIFO_AW+1)'(RD_FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign wr_fire     = (state_q == WRITE) && ch_wr_valid[grant_q];
  // A full buffer refuses memory data even when a pop happens this cycle.
  assign rd_accept   = (state_q == READ) && !fifo_full && (rx_cnt_q < beats_total);
  assign push        = rd_accept && mem_rd_valid;
  assign pop         = (state_q == READ) && !fifo_empty && ch_rd_ready[grant_q];

  always_comb begin
    state_d        = state_q;
    ch_req_ready   = '0;
    ch_wr_ready    = '0;
    ch_rd_valid    = '0;
    ch_rd_bits     = '0;
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    mem_req_len    = '0;
    mem_req_addr   = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    mem_rd_ready   = 1'b0;
    fsm_state      = 2'd0;
    case (state_q)
      IDLE:    if (grant_found) state_d = REQ;
      REQ:     state_d = op_q ? WRITE : READ;
      WRITE:   if (wr_fire && last_beat) state_d = IDLE;
      READ:    if (pop && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Every output is held at zero while reset is asserted.
    if (!reset) begin
      fsm_state = state_q;
      case (state_q)
        IDLE: if (grant_found) ch_req_ready[grant_d] = 1'b1;
        REQ: begin
          mem_req_valid  = 1'b1;
          mem_req_opcode = op_q;
          mem_req_len    = len_q;
          mem_req_addr   = addr_q;
        end
        WRITE: begin
          ch_wr_ready[grant_q] = 1'b1;
          mem_wr_valid         = ch_wr_valid[grant_q];
          mem_wr_bits          = wdat_arr[grant_q];
        end
        READ: begin
          mem_rd_ready         = rd_accept;
          ch_rd_valid[grant_q] = !fifo_empty;
          ch_rd_bits           = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      op_q       <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      rx_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_found) begin
        grant_q    <= grant_d;
        op_q       <= ch_req_opcode[grant_d];
        len_q      <= len_arr[grant_d];
        addr_q     <= addr_arr[grant_d];
        rr_ptr_q   <= ptr_next;
        beat_cnt_q <= '0;
        rx_cnt_q   <= '0;
      end
      if (wr_fire || pop) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (FIFO_AW+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rd_bits;
  end

endmodule

// File: tb/tb_vta_mem_mux.sv
// Bench for vta_mem_mux: directed bursts with literal expectations, then random
// traffic checked every cycle against a burst-level model of the multiplexer.
module tb_vta_mem_mux;

  localparam int NC = 3;
  localparam int LB = 8;
  localparam int AB = 64;
  localparam int DB = 64;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_REQ = 1, P_WRITE = 2, P_READ = 3;

  logic              clock, reset;
  logic [NC-1:0]     ch_req_valid, ch_req_ready, ch_req_opcode;
  logic [NC*LB-1:0]  ch_req_len;
  logic [NC*AB-1:0]  ch_req_addr;
  logic [NC-1:0]     ch_wr_valid, ch_wr_ready;
  logic [NC*DB-1:0]  ch_wr_bits;
  logic [NC-1:0]     ch_rd_valid, ch_rd_ready;
  logic [DB-1:0]     ch_rd_bits;
  logic              mem_req_valid, mem_req_opcode;
  logic [LB-1:0]     mem_req_len;
  logic [AB-1:0]     mem_req_addr;
  logic              mem_wr_valid;
  logic [DB-1:0]     mem_wr_bits;
  logic              mem_rd_valid, mem_rd_ready;
  logic [DB-1:0]     mem_rd_bits;
  logic [1:0]        fsm_state;
  logic              any_out;

  vta_mem_mux #(.NUM_CH(NC), .LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB),
                .RD_FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_opcode(ch_req_opcode), .ch_req_len(ch_req_len), .ch_req_addr(ch_req_addr),
    .ch_wr_valid(ch_wr_valid), .ch_wr_ready(ch_wr_ready), .ch_wr_bits(ch_wr_bits),
    .ch_rd_valid(ch_rd_valid), .ch_rd_ready(ch_rd_ready), .ch_rd_bits(ch_rd_bits),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
    .fsm_state(fsm_state)
  );

  assign any_out = |{ch_req_ready, ch_wr_ready, ch_rd_valid, ch_rd_bits, mem_req_valid,
                     mem_req_opcode, mem_req_len, mem_req_addr, mem_wr_valid, mem_wr_bits,
                     mem_rd_ready, fsm_state};

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model of the burst currently being served; exp_q holds the
  // read data accepted from memory and not yet handed to the client.
  logic [DB-1:0] exp_q[$];
  bit            model_on = 0;
  int            m_phase, m_ptr, m_g, m_len, m_cnt, m_rx;
  logic          m_op;
  logic [AB-1:0] m_addr;

  // Logs of what the DUT did, used by the directed tests.
  int            grant_log[$];
  logic [DB-1:0] rd_got_q[$];
  logic [DB-1:0] wr_got_q[$];
  int            req_count;
  logic          req_op;
  logic [LB-1:0] req_len;
  logic [AB-1:0] req_addr;
  bit            wr0_seen;
  int            rd_idx;

  bit            rand_mode = 0;
  bit            mem_auto  = 0;
  logic [DB-1:0] rd_base   = '0;

  // ---------------- memory responder ----------------
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_bits  = '0;
    forever begin
      @(posedge clock); #1;
      if (rand_mode) begin
        mem_rd_valid = ($urandom_range(0, 3) != 0);
        mem_rd_bits  = {$urandom, $urandom};
      end else if (mem_auto) begin
        mem_rd_valid = 1'b1;
        mem_rd_bits  = rd_base + 64'(rd_idx);
      end else begin
        mem_rd_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor + model compare ----------------
  always @(negedge clock) begin : monitor
    logic [NC-1:0] e_req, e_wr, e_rdv;
    logic e_mreq, e_mwv, e_mrr, e_pop, e_push;
    int w, c;
    e_req = '0; e_wr = '0; e_rdv = '0;
    e_mreq = 0; e_mwv = 0; e_mrr = 0; e_pop = 0; e_push = 0;
    w = -1; c = 0;
    if (reset) begin
      check("reset_outputs_zero", any_out, 1'b0);
      model_on = 1;
      m_phase = P_IDLE; m_ptr = 0; m_g = 0; m_len = 0; m_cnt = 0; m_rx = 0;
      m_op = 0; m_addr = '0;
      exp_q.delete();
      grant_log.delete(); rd_got_q.delete(); wr_got_q.delete();
      req_count = 0; wr0_seen = 0; rd_idx = 0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (ch_req_ready[k]) grant_log.push_back(k);
        if (ch_rd_valid[k] && ch_rd_ready[k]) rd_got_q.push_back(ch_rd_bits);
      end
      if (mem_req_valid) begin
        req_count++; req_op = mem_req_opcode; req_len = mem_req_len; req_addr = mem_req_addr;
      end
      if (ch_wr_ready[0]) wr0_seen = 1;
      if (mem_wr_valid) wr_got_q.push_back(mem_wr_bits);
      if (mem_rd_valid && mem_rd_ready) rd_idx++;

      if (model_on) begin
        if (m_phase == P_IDLE)
          for (int k = 0; k < NC; k++) begin
            c = (m_ptr + k) % NC;
            if (w < 0 && ch_req_valid[c]) w = c;
          end
        if (w >= 0) e_req[w] = 1'b1;
        e_mreq = (m_phase == P_REQ);
        if (m_phase == P_WRITE) begin
          e_wr[m_g] = 1'b1;
          e_mwv = ch_wr_valid[m_g];
        end
        if (m_phase == P_READ) begin
          e_mrr = (exp_q.size() < DEPTH) && (m_rx < m_len + 1);
          e_rdv[m_g] = (exp_q.size() > 0);
          e_pop  = e_rdv[m_g] && ch_rd_ready[m_g];
          e_push = e_mrr && mem_rd_valid;
        end
        check("handshakes",
              {ch_req_ready, ch_wr_ready, ch_rd_valid, mem_req_valid, mem_wr_valid, mem_rd_ready, fsm_state},
              {e_req, e_wr, e_rdv, e_mreq, e_mwv, e_mrr, 2'(m_phase)});
        if (e_mreq) begin
          check("mem_req_addr", mem_req_addr, m_addr);
          check("mem_req_op_len", {mem_req_opcode, mem_req_len}, {m_op, 8'(m_len)});
        end
        if (e_mwv) check("mem_wr_bits", mem_wr_bits, ch_wr_bits[m_g*DB +: DB]);
        if (e_rdv != 0) check("ch_rd_bits", ch_rd_bits, exp_q[0]);

        case (m_phase)
          P_IDLE: if (w >= 0) begin
            m_g = w; m_op = ch_req_opcode[w];
            m_len = int'(ch_req_len[w*LB +: LB]); m_addr = ch_req_addr[w*AB +: AB];
            m_ptr = (w + 1) % NC; m_cnt = 0; m_rx = 0; m_phase = P_REQ;
          end
          P_REQ: m_phase = m_op ? P_WRITE : P_READ;
          P_WRITE: if (ch_wr_valid[m_g]) begin
            m_cnt++;
            if (m_cnt == m_len + 1) m_phase = P_IDLE;
          end
          default: begin
            if (e_pop) begin void'(exp_q.pop_front()); m_cnt++; end
            if (e_push) begin exp_q.push_back(mem_rd_bits); m_rx++; end
            if (e_pop && m_cnt == m_len + 1) m_phase = P_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    ch_req_valid = '0; ch_wr_valid = '0; ch_rd_ready = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic issue(input int ch, input logic op, input int len, input logic [63:0] addr);
    bit got;
    got = 0;
    ch_req_opcode[ch] = op;
    ch_req_len[ch*LB +: LB] = LB'(len);
    ch_req_addr[ch*AB +: AB] = addr;
    ch_req_valid[ch] = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clock);
      got = ch_req_ready[ch];
    end
    check("grant_seen", got, 1'b1);
    @(posedge clock); #1;
    ch_req_valid[ch] = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int k = 0; k < budget && rd_got_q.size() < n; k++) @(negedge clock);
  endtask

  task automatic wait_wr_accept(input int ch);
    bit got;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      got = ch_wr_ready[ch];
    end
    check("wr_accept_seen", got, 1'b1);
    @(posedge clock); #1;
    ch_wr_valid[ch] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    reset = 1'b1;
    ch_req_valid = '0; ch_req_opcode = '0; ch_req_len = '0; ch_req_addr = '0;
    ch_wr_valid = '0; ch_wr_bits = '0; ch_rd_ready = '0;
    mem_auto = 1;

    // Read on ch0, len 3, back-to-back memory data, consumer always ready.
    do_reset();
    rd_base = 64'hA0;
    ch_rd_ready = 3'b001;
    @(negedge clock);
    check("t1_rd_ready_idle", mem_rd_ready, 1'b0);
    @(posedge clock); #1;
    issue(0, 1'b0, 3, 64'h1000);
    wait_rd(4, 50);
    repeat (2) @(negedge clock);
    check("t1_req_count", req_count, 1);
    check("t1_req_fields", {req_op, req_len}, {1'b0, 8'd3});
    check("t1_req_addr", req_addr, 64'h1000);
    check("t1_rd_count", rd_got_q.size(), 4);
    for (int k = 0; k < 4 && k < rd_got_q.size(); k++)
      check("t1_rd_data", rd_got_q[k], 64'hA0 + 64'(k));
    check("t1_idle", fsm_state, 2'd0);

    // Two channels holding requests: grants alternate, ch0 first.
    do_reset();
    ch_req_opcode = '0; ch_req_len = '0; ch_rd_ready = 3'b111;
    ch_req_valid = 3'b011;
    for (int k = 0; k < 100 && grant_log.size() < 4; k++) @(negedge clock);
    @(posedge clock); #1;
    ch_req_valid = '0;
    check("t2_grant_count_ge4", grant_log.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("t2_grant_order", grant_log[k], k % 2);
    repeat (10) @(posedge clock);

    // Read len 7 into a stalled consumer: buffer fills at 4, then drains in order.
    do_reset();
    rd_base = 64'hB0;
    ch_rd_ready = '0;
    issue(0, 1'b0, 7, 64'h3000);
    repeat (12) @(negedge clock);
    check("t3_beats_before_stall", rd_idx, 4);
    check("t3_mem_rd_ready_low", mem_rd_ready, 1'b0);
    check("t3_rd_valid", ch_rd_valid, 3'b001);
    @(posedge clock); #1;
    ch_rd_ready = 3'b001;
    wait_rd(8, 60);
    repeat (2) @(negedge clock);
    check("t3_rd_count", rd_got_q.size(), 8);
    for (int k = 0; k < 8 && k < rd_got_q.size(); k++)
      check("t3_rd_data", rd_got_q[k], 64'hB0 + 64'(k));
    check("t3_idle", fsm_state, 2'd0);

    // Write len 1 on ch1 with a 3-cycle gap between beats.
    do_reset();
    issue(1, 1'b1, 1, 64'h2000);
    ch_wr_bits[0 +: DB]  = 64'hDEAD;
    ch_wr_bits[DB +: DB] = 64'h11;
    ch_wr_valid[1] = 1'b1;
    wait_wr_accept(1);
    repeat (3) @(posedge clock);
    #1;
    ch_wr_bits[DB +: DB] = 64'h22;
    ch_wr_valid[1] = 1'b1;
    wait_wr_accept(1);
    repeat (3) @(negedge clock);
    check("t4_wr_count", wr_got_q.size(), 2);
    if (wr_got_q.size() == 2) begin
      check("t4_wr_beat0", wr_got_q[0], 64'h11);
      check("t4_wr_beat1", wr_got_q[1], 64'h22);
    end
    check("t4_req_fields", {req_op, req_len}, {1'b1, 8'd1});
    check("t4_ch0_wr_ready_never", wr0_seen, 1'b0);
    check("t4_idle", fsm_state, 2'd0);

    // Reset after 2 of 4 read beats, then a fresh ch1 read right after reset.
    do_reset();
    rd_base = 64'hC0;
    ch_rd_ready = 3'b001;
    issue(0, 1'b0, 3, 64'h4000);
    wait_rd(2, 30);
    @(posedge clock); #1;
    reset = 1'b1;
    rd_base = 64'hD0;
    @(negedge clock);
    check("t5_outputs_zero", any_out, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    ch_rd_ready = 3'b010;
    ch_req_opcode[1] = 1'b0;
    ch_req_len[LB +: LB] = 8'd3;
    ch_req_addr[AB +: AB] = 64'h5000;
    ch_req_valid[1] = 1'b1;
    @(negedge clock);
    check("t5_fifo_empty", ch_rd_valid, 3'b000);
    check("t5_grant_after_reset", ch_req_ready, 3'b010);
    @(posedge clock); #1;
    ch_req_valid[1] = 1'b0;
    wait_rd(4, 50);
    repeat (2) @(negedge clock);
    check("t5_rd_count", rd_got_q.size(), 4);
    for (int k = 0; k < 4 && k < rd_got_q.size(); k++)
      check("t5_rd_data", rd_got_q[k], 64'hD0 + 64'(k));
    check("t5_idle", fsm_state, 2'd0);

    // Maximum length read: 256 beats, no wrap.
    do_reset();
    rd_base = 64'h5500_0000;
    ch_rd_ready = 3'b001;
    issue(0, 1'b0, 255, 64'h6000);
    wait_rd(256, 1000);
    repeat (5) @(negedge clock);
    check("t6_rd_count", rd_got_q.size(), 256);
    check("t6_mem_beats", rd_idx, 256);
    bad = 0;
    for (int k = 0; k < rd_got_q.size(); k++)
      if (rd_got_q[k] !== 64'h5500_0000 + 64'(k)) bad++;
    check("t6_rd_order_errors", bad, 0);
    check("t6_idle", fsm_state, 2'd0);

    // Random traffic with occasional reset, checked by the model every cycle.
    do_reset();
    rand_mode = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 399) == 0);
      ch_req_valid  = NC'($urandom_range(0, 7));
      ch_req_opcode = NC'($urandom_range(0, 7));
      for (int c = 0; c < NC; c++) begin
        ch_req_len[c*LB +: LB] = ($urandom_range(0, 15) == 0) ? LB'($urandom_range(0, 255))
                                                              : LB'($urandom_range(0, 4));
        ch_req_addr[c*AB +: AB] = {$urandom, $urandom};
        ch_wr_bits[c*DB +: DB]  = {$urandom, $urandom};
        ch_rd_ready[c] = ($urandom_range(0, 9) < 7);
      end
      ch_wr_valid = NC'($urandom_range(0, 7));
    end
    @(posedge clock); #1;
    rand_mode = 0;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
